core_memory_arbiter: RTL and testbench
======================================

# core_memory_arbiter

Two-requester arbiter that shares the single core-side memory port (address/byteSelect/read/write/busy) of the core memory controller between the instruction-fetch unit and the load/store unit. Sits between the pipeline and the memory controller. Grants one requester at a time with round-robin fairness and holds the grant until the downstream transfer completes. Read data and busy are routed back to the owner of the grant.

## Interface
Parameters:
- TIMEOUT_CYCLES, 256: downstream busy cycles before a grant is aborted. Used only with the timeout feature. Range 1..65535.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- fetchAddress  in  32  fetch request address
- fetchReadEnable  in  1  fetch read request; held until fetchBusy=0
- fetchDataRead  out  32  fetch read data, valid in the completion cycle
- fetchBusy  out  1  fetch stall
- dataAddress  in  32  load/store address
- dataByteSelect  in  4  load/store byte lanes
- dataWriteEnable  in  1  store request
- dataReadEnable  in  1  load request
- dataDataWrite  in  32  store data
- dataDataRead  out  32  load data, valid in the completion cycle
- dataBusy  out  1  load/store stall
- memAddress  out  32  to memory controller coreAddress
- memByteSelect  out  4  to coreByteSelect; fetch grant drives 4'b1111
- memWriteEnable  out  1  to coreWriteEnable
- memReadEnable  out  1  to coreReadEnable
- memDataWrite  out  32  to coreDataWrite
- memDataRead  in  32  from coreDataRead
- memBusy  in  1  from coreBusy
- timeoutError  out  1  one-cycle pulse on grant abort; constant 0 without the timeout feature

## Operation
- Request: fetchReq = fetchReadEnable; dataReq = dataReadEnable | dataWriteEnable.
- States: IDLE, GRANT_FETCH, GRANT_DATA. Round-robin pointer lastGrant (0 = fetch, 1 = data).
- IDLE: if exactly one request is set, go to its GRANT state. If both are set, grant the requester that does not match lastGrant. Otherwise stay in IDLE.
- In GRANT_x: mem* driven combinationally from requester x. In IDLE: mem* all 0.
- Completion: a cycle in GRANT_x with request x still set and memBusy=0.
  - xBusy=0 and xDataRead=memDataRead in that cycle.
  - lastGrant<=x.
  - Next state is GRANT_other if the other request is set, else IDLE.
- Withdrawal: if request x drops while in GRANT_x, mem* go to 0 in that cycle and the next state is IDLE. lastGrant is unchanged.
- Busy: xBusy = xReq & ~(state==GRANT_x & ~memBusy). A requester with no request sees busy=0.
- Read data: xDataRead = memDataRead when state==GRANT_x, else 32'b0.
- Requesters must hold address, byte select, enables and write data stable while busy is 1.

## Timing
- Reset: state=IDLE, lastGrant=1 (fetch wins the first tie), timeout counter=0, timeoutError=0.
  - All mem* outputs are 0.
  - fetchDataRead and dataDataRead are 0.
  - fetchBusy and dataBusy follow their requests, i.e. 1 if a request is held during reset.
- Arbitration latency: 1 cycle from IDLE.
  - A request raised in cycle N appears on mem* in cycle N+1.
  - With memBusy=0, that request completes in cycle N+1.
- Back-to-back: a different requester follows with zero bubble. The same requester re-requesting passes through IDLE, costing one bubble.
- Simultaneous requests from IDLE: resolved by lastGrant. Alternating contention yields the pattern F, D, F, D.
- Reset asserted mid-grant: mem* go to 0 immediately (asynchronous). No completion is reported.

## Configuration
- CORE_MEMORY_ARBITER_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to a GRANT state and increments each grant cycle with memBusy=1.
  - When it reaches TIMEOUT_CYCLES, that cycle is a forced completion:
    - xBusy=0.
    - xDataRead=32'hFFFF_FFFF.
    - timeoutError=1 for that cycle.
    - mem* go to 0 in that cycle.
    - Next state is IDLE and lastGrant<=x.
- Undefined: no counter is instantiated, timeoutError is tied to 0, and a grant waits indefinitely on memBusy.

## Test plan
- Fetch only: fetchAddress=0x0000_0100, memBusy=0, memDataRead=0x1234_5678 → mem* active one cycle after the request; fetchBusy=0 and fetchDataRead=0x1234_5678 that cycle.
- Store with wait states: dataWriteEnable=1, dataAddress=0x1000_0040, dataByteSelect=4'b0011, dataDataWrite=0xCAFE_BABE, memBusy=1 for 3 cycles → dataBusy=1 for 4 cycles then 0; memWriteEnable=1 for 4 cycles; fetch mem outputs never driven.
- Contention: fetch and data both held continuously from reset, memBusy=0 → grants F, D, F, D with no IDLE bubble; each busy drops on alternate cycles.
- Withdrawal: dataReadEnable drops after one cycle in GRANT_DATA with memBusy=1 → mem* are 0 in the same cycle; IDLE next cycle; a pending fetch is granted on the following cycle.
- Async reset mid-grant: rst pulses while in GRANT_FETCH with memBusy=1 → memReadEnable=0 without waiting for a clock edge; after reset release, a tie is granted to fetch.
- With CORE_MEMORY_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=4: memBusy stuck at 1 → forced completion on the 4th busy cycle; dataDataRead=0xFFFF_FFFF and timeoutError=1 for one cycle; arbiter back in IDLE next cycle.

Source files
------------

// File: rtl/core_memory_arbiter.sv
// Round-robin arbiter sharing the core memory port between instruction fetch and load/store.
// Optional grant-abort timeout is compiled in when CORE_MEMORY_ARBITER_TIMEOUT_EN is defined.
module core_memory_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetchAddress,
    input  logic        fetchReadEnable,
    output logic [31:0] fetchDataRead,
    output logic        fetchBusy,
    input  logic [31:0] dataAddress,
    input  logic [3:0]  dataByteSelect,
    input  logic        dataWriteEnable,
    input  logic        dataReadEnable,
    input  logic [31:0] dataDataWrite,
    output logic [31:0] dataDataRead,
    output logic        dataBusy,
    output logic [31:0] memAddress,
    output logic [3:0]  memByteSelect,
    output logic        memWriteEnable,
    output logic        memReadEnable,
    output logic [31:0] memDataWrite,
    input  logic [31:0] memDataRead,
    input  logic        memBusy,
    output logic        timeoutError
);
    // state      | meaning
    // ST_IDLE    | no grant, memory port driven to 0
    // ST_GRANT_F | fetch owns the memory port
    // ST_GRANT_D | load/store owns the memory port
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_F = 2'd1,
        ST_GRANT_D = 2'd2
    } state_e;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("core_memory_arbiter: TIMEOUT_CYCLES out of range 1..65535");
    end

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   fetch_req, data_req, timeout_hit;

    assign fetch_req = fetchReadEnable;
    assign data_req  = dataReadEnable | dataWriteEnable;

`ifdef CORE_MEMORY_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        in_grant, grant_held;

    assign in_grant   = (state_q != ST_IDLE);
    assign grant_held = (state_q == ST_GRANT_F) ? fetch_req :
                        (state_q == ST_GRANT_D) ? data_req  : 1'b0;
    // Counter holds busy cycles already seen, so the abort lands on the TIMEOUT_CYCLES-th one.
    assign timeout_hit = grant_held & memBusy & (tmo_cnt_q == TMO_LAST);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (!in_grant || state_d != state_q) begin
            tmo_cnt_d = '0;
        end else if (memBusy) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign timeoutError = timeout_hit;

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        memAddress     = '0;
        memByteSelect  = '0;
        memWriteEnable = 1'b0;
        memReadEnable  = 1'b0;
        memDataWrite   = '0;
        fetchBusy      = fetch_req;
        dataBusy       = data_req;
        fetchDataRead  = '0;
        dataDataRead   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (fetch_req && data_req) begin
                    state_d = last_grant_q ? ST_GRANT_F : ST_GRANT_D;
                end else if (fetch_req) begin
                    state_d = ST_GRANT_F;
                end else if (data_req) begin
                    state_d = ST_GRANT_D;
                end
            end
            ST_GRANT_F: begin
                fetchDataRead = memDataRead;
                if (!fetch_req) begin
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    fetchBusy     = 1'b0;
                    fetchDataRead = '1;
                    last_grant_d  = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    memAddress    = fetchAddress;
                    memByteSelect = 4'b1111;
                    memReadEnable = 1'b1;
                    if (!memBusy) begin
                        fetchBusy    = 1'b0;
                        last_grant_d = 1'b0;
                        state_d      = data_req ? ST_GRANT_D : ST_IDLE;
                    end
                end
            end
            ST_GRANT_D: begin
                dataDataRead = memDataRead;
                if (!data_req) begin
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    dataBusy     = 1'b0;
                    dataDataRead = '1;
                    last_grant_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    memAddress     = dataAddress;
                    memByteSelect  = dataByteSelect;
                    memWriteEnable = dataWriteEnable;
                    memReadEnable  = dataReadEnable;
                    memDataWrite   = dataDataWrite;
                    if (!memBusy) begin
                        dataBusy     = 1'b0;
                        last_grant_d = 1'b1;
                        state_d      = fetch_req ? ST_GRANT_F : ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // lastGrant resets to data so that fetch wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end
endmodule

// File: tb/tb_core_memory_arbiter.sv
// Self-checking bench for core_memory_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural owner/lastGrant model.
module tb_core_memory_arbiter;
    localparam int TMO = 4;
`ifdef CORE_MEMORY_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst = 1'b1;
    logic [31:0] fetchAddress = '0;
    logic        fetchReadEnable = 1'b0;
    logic [31:0] fetchDataRead;
    logic        fetchBusy;
    logic [31:0] dataAddress = '0;
    logic [3:0]  dataByteSelect = '0;
    logic        dataWriteEnable = 1'b0;
    logic        dataReadEnable = 1'b0;
    logic [31:0] dataDataWrite = '0;
    logic [31:0] dataDataRead;
    logic        dataBusy;
    logic [31:0] memAddress;
    logic [3:0]  memByteSelect;
    logic        memWriteEnable;
    logic        memReadEnable;
    logic [31:0] memDataWrite;
    logic [31:0] memDataRead = '0;
    logic        memBusy = 1'b0;
    logic        timeoutError;

    core_memory_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .fetchAddress(fetchAddress), .fetchReadEnable(fetchReadEnable),
        .fetchDataRead(fetchDataRead), .fetchBusy(fetchBusy),
        .dataAddress(dataAddress), .dataByteSelect(dataByteSelect),
        .dataWriteEnable(dataWriteEnable), .dataReadEnable(dataReadEnable),
        .dataDataWrite(dataDataWrite), .dataDataRead(dataDataRead), .dataBusy(dataBusy),
        .memAddress(memAddress), .memByteSelect(memByteSelect),
        .memWriteEnable(memWriteEnable), .memReadEnable(memReadEnable),
        .memDataWrite(memDataWrite), .memDataRead(memDataRead), .memBusy(memBusy),
        .timeoutError(timeoutError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    // Model: owner -1 none, 0 fetch, 1 data; last = requester that last completed.
    int m_own, m_last, m_cnt;
    int n_own, n_last, n_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_own = -1; m_last = 1; m_cnt = 0;
    endtask

    task automatic model_check();
        logic [1:0]  rq;
        logic [31:0] e_addr, e_wd, e_fr, e_dr;
        logic [3:0]  e_be;
        logic        e_we, e_re, e_te;
        logic [1:0]  e_busy;
        int x;
        rq[0] = fetchReadEnable;
        rq[1] = dataReadEnable | dataWriteEnable;
        e_addr = '0; e_wd = '0; e_fr = '0; e_dr = '0; e_be = '0;
        e_we = 1'b0; e_re = 1'b0; e_te = 1'b0;
        e_busy = rq;
        n_own = m_own; n_last = m_last; n_cnt = m_cnt;
        if (rst) begin
            n_own = -1; n_last = 1; n_cnt = 0;
        end else if (m_own < 0) begin
            n_cnt = 0;
            if (rq == 2'b11) n_own = 1 - m_last;
            else if (rq[0])  n_own = 0;
            else if (rq[1])  n_own = 1;
        end else begin
            x = m_own;
            if (x == 0) e_fr = memDataRead; else e_dr = memDataRead;
            if (!rq[x]) begin
                n_own = -1;
            end else if (TO_EN && memBusy && (m_cnt + 1 == TMO)) begin
                e_busy[x] = 1'b0;
                e_te = 1'b1;
                if (x == 0) e_fr = 32'hFFFF_FFFF; else e_dr = 32'hFFFF_FFFF;
                n_own = -1; n_last = x;
            end else begin
                if (x == 0) begin
                    e_addr = fetchAddress; e_be = 4'hF; e_re = 1'b1;
                end else begin
                    e_addr = dataAddress; e_be = dataByteSelect; e_re = dataReadEnable;
                    e_we = dataWriteEnable; e_wd = dataDataWrite;
                end
                if (!memBusy) begin
                    e_busy[x] = 1'b0;
                    n_last = x; n_cnt = 0;
                    n_own = rq[1-x] ? 1 - x : -1;
                end else begin
                    n_cnt = m_cnt + 1;
                end
            end
        end
        chk("memAddress", memAddress, e_addr);
        chk("memByteSelect", memByteSelect, e_be);
        chk("memWriteEnable", memWriteEnable, e_we);
        chk("memReadEnable", memReadEnable, e_re);
        chk("memDataWrite", memDataWrite, e_wd);
        chk("fetchBusy", fetchBusy, e_busy[0]);
        chk("dataBusy", dataBusy, e_busy[1]);
        chk("fetchDataRead", fetchDataRead, e_fr);
        chk("dataDataRead", dataDataRead, e_dr);
        chk("timeoutError", timeoutError, e_te);
    endtask

    task automatic neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic pos();
        @(posedge clk);
        if (rst) m_reset();
        else begin
            m_own = n_own; m_last = n_last; m_cnt = n_cnt;
        end
        #1;
    endtask

    int bc, wc, rc, r;
    logic [3:0] gpat;
    logic f_done, d_done;

    initial begin
        m_reset();
        // reset with a fetch request held
        fetchReadEnable = 1'b1;
        neg();
        chk("rst_fetchBusy", fetchBusy, 1'b1);
        chk("rst_memRE", memReadEnable, 1'b0);
        chk("rst_fetchDataRead", fetchDataRead, 32'h0);
        chk("rst_dataBusy", dataBusy, 1'b0);
        pos(); fetchReadEnable = 1'b0;
        neg(); pos(); rst = 1'b0;

        // fetch only
        fetchReadEnable = 1'b1; fetchAddress = 32'h0000_0100;
        memBusy = 1'b0; memDataRead = 32'h1234_5678;
        neg();
        chk("fo_idle_memRE", memReadEnable, 1'b0);
        chk("fo_idle_busy", fetchBusy, 1'b1);
        pos();
        neg();
        chk("fo_memRE", memReadEnable, 1'b1);
        chk("fo_memAddress", memAddress, 32'h0000_0100);
        chk("fo_memBE", memByteSelect, 4'hF);
        chk("fo_busy", fetchBusy, 1'b0);
        chk("fo_rdata", fetchDataRead, 32'h1234_5678);
        pos(); fetchReadEnable = 1'b0;
        neg(); pos();

        // store with three wait states
        dataWriteEnable = 1'b1; dataAddress = 32'h1000_0040; dataByteSelect = 4'b0011;
        dataDataWrite = 32'hCAFE_BABE; memBusy = 1'b1;
        bc = 0; wc = 0; rc = 0;
        for (int i = 0; i < 6; i++) begin
            neg();
            if (dataBusy) bc++;
            if (memWriteEnable) wc++;
            if (memReadEnable || memByteSelect == 4'hF) rc++;
            if (i == 1) begin
                chk("st_memDataWrite", memDataWrite, 32'hCAFE_BABE);
                chk("st_memBE", memByteSelect, 4'b0011);
                chk("st_memAddress", memAddress, 32'h1000_0040);
            end
            if (i == 4) chk("st_busy_drop", dataBusy, 1'b0);
            pos();
            if (i == 3) memBusy = 1'b0;
            if (i == 4) dataWriteEnable = 1'b0;
        end
        chk("st_busy_cycles", bc, 4);
        chk("st_we_cycles", wc, 4);
        chk("st_fetch_driven", rc, 0);

        // contention from reset
        rst = 1'b1; m_reset();
        fetchReadEnable = 1'b1; dataReadEnable = 1'b1; dataByteSelect = 4'h5;
        neg(); pos(); rst = 1'b0;
        neg();
        chk("ct_idle_memRE", memReadEnable, 1'b0);
        pos();
        gpat = '0;
        for (int i = 0; i < 4; i++) begin
            neg();
            gpat[i] = (memByteSelect == 4'h5);
            chk("ct_busy_alt", {fetchBusy, dataBusy}, (i % 2 == 0) ? 2'b01 : 2'b10);
            pos();
        end
        chk("ct_grant_pattern", gpat, 4'b1010);
        fetchReadEnable = 1'b0; dataReadEnable = 1'b0;
        neg(); pos();
        neg(); pos();

        // withdrawal
        dataReadEnable = 1'b1; dataAddress = 32'h2000_0000; memBusy = 1'b1;
        neg(); pos();
        neg();
        chk("wd_grant_memRE", memReadEnable, 1'b1);
        pos(); dataReadEnable = 1'b0; fetchReadEnable = 1'b1; fetchAddress = 32'h0000_0200;
        neg();
        chk("wd_memRE", memReadEnable, 1'b0);
        chk("wd_memAddress", memAddress, 32'h0);
        chk("wd_fetchBusy", fetchBusy, 1'b1);
        pos();
        neg();
        chk("wd_idle_memRE", memReadEnable, 1'b0);
        pos();
        neg();
        chk("wd_fetch_memRE", memReadEnable, 1'b1);
        chk("wd_fetch_memAddress", memAddress, 32'h0000_0200);

        // async reset mid-grant, fetch still held with memBusy=1
        #2 rst = 1'b1; m_reset();
        #1;
        chk("ar_memRE", memReadEnable, 1'b0);
        chk("ar_memAddress", memAddress, 32'h0);
        chk("ar_fetchBusy", fetchBusy, 1'b1);
        pos(); rst = 1'b0; dataReadEnable = 1'b1;
        neg();
        chk("ar_idle_memRE", memReadEnable, 1'b0);
        pos();
        neg();
        chk("ar_tie_fetch", memByteSelect, 4'hF);
        pos(); memBusy = 1'b0;
        neg(); pos(); fetchReadEnable = 1'b0;
        neg(); pos(); dataReadEnable = 1'b0;
        neg(); pos();

`ifdef CORE_MEMORY_ARBITER_TIMEOUT_EN
        dataReadEnable = 1'b1; memBusy = 1'b1; memDataRead = 32'h5555_AAAA;
        for (int i = 0; i < 6; i++) begin
            neg();
            if (i == 3) chk("to_not_yet", timeoutError, 1'b0);
            if (i == 4) begin
                chk("to_rdata", dataDataRead, 32'hFFFF_FFFF);
                chk("to_err", timeoutError, 1'b1);
                chk("to_busy", dataBusy, 1'b0);
                chk("to_memRE", memReadEnable, 1'b0);
            end
            if (i == 5) begin
                chk("to_err_pulse", timeoutError, 1'b0);
                chk("to_idle_memRE", memReadEnable, 1'b0);
            end
            pos();
            if (i == 4) dataReadEnable = 1'b0;
        end
        memBusy = 1'b0;
`endif

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            neg();
            f_done = fetchReadEnable && !fetchBusy;
            d_done = (dataReadEnable || dataWriteEnable) && !dataBusy;
            pos();
            if (fetchReadEnable && !f_done) begin
                if ($urandom_range(15) == 0) fetchReadEnable = 1'b0;
            end else begin
                fetchReadEnable = ($urandom_range(2) != 0);
                fetchAddress = $urandom;
            end
            if ((dataReadEnable || dataWriteEnable) && !d_done) begin
                if ($urandom_range(15) == 0) begin
                    dataReadEnable = 1'b0; dataWriteEnable = 1'b0;
                end
            end else begin
                r = int'($urandom_range(3));
                dataReadEnable = (r == 1);
                dataWriteEnable = (r == 2);
                dataAddress = $urandom;
                dataByteSelect = 4'($urandom);
                dataDataWrite = $urandom;
            end
            memBusy = ($urandom_range(9) < 4);
            memDataRead = $urandom;
        end
        neg();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
